// File: rtl/sa_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sa_fifo_pkg
// Shared sizing constants and typedefs for the 128x6 FIFO controller and
// the single-port-pair RAM it sequences.
// Ports: none (package).
// ----------------------------------------------------------------------------
package sa_fifo_pkg;

    localparam int SA_FIFO_DEPTH = 128;
    localparam int SA_FIFO_AW    = 7;
    localparam int SA_FIFO_DW    = 6;

    // Pointers wrap 127 -> 0 naturally at 7 bits.
    typedef logic [SA_FIFO_AW-1:0] sa_fifo_ptr_t;
    // Counts must reach 129 (128 RAM slots + output register), hence 8 bits.
    typedef logic [7:0]            sa_fifo_cnt_t;

endpackage

// File: rtl/sa_fifo_ctrl_128x6_if.sv
// ----------------------------------------------------------------------------
// sa_fifo_ctrl_128x6_if
// Push/pop handshake bundle of the 128x6 FIFO controller.
//   wr_pvld/wr_prdy/wr_pd : producer side, wr_afull = almost-full flag
//   rd_pvld/rd_prdy/rd_pd : consumer side
// Modports: slave = the FIFO controller, master = the environment around it.
// ----------------------------------------------------------------------------
interface sa_fifo_ctrl_128x6_if;
    import sa_fifo_pkg::*;

    logic                  wr_pvld;
    logic                  wr_prdy;
    logic [SA_FIFO_DW-1:0] wr_pd;
    logic                  wr_afull;
    logic                  rd_pvld;
    logic                  rd_prdy;
    logic [SA_FIFO_DW-1:0] rd_pd;

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy,
        output wr_prdy, wr_afull, rd_pvld, rd_pd
    );

    modport master (
        output wr_pvld, wr_pd, rd_prdy,
        input  wr_prdy, wr_afull, rd_pvld, rd_pd
    );

endinterface

// File: rtl/sa_ram_rwsp_128x6.sv
// ----------------------------------------------------------------------------
// sa_ram_rwsp_128x6
// 128x6 RAM, one write port and a two-stage read pipeline:
//   re  : capture read address ra into the address register
//   ore : capture mem[address register] into the output register
// Ports: clk; we/wa/di write port; re/ra, ore read pipeline controls;
//        dout = output register; pwrbus_ram_pd = power-control bus (unused
//        by this behavioural model).
// ----------------------------------------------------------------------------
module sa_ram_rwsp_128x6
    import sa_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  re,
    input  logic                  ore,
    input  sa_fifo_ptr_t          ra,
    input  logic                  we,
    input  sa_fifo_ptr_t          wa,
    input  logic [SA_FIFO_DW-1:0] di,
    input  logic [31:0]           pwrbus_ram_pd,
    output logic [SA_FIFO_DW-1:0] dout
);

    logic [SA_FIFO_DW-1:0] mem [SA_FIFO_DEPTH];
    sa_fifo_ptr_t          ra_q;
    logic [SA_FIFO_DW-1:0] dout_q;

    // NOTE: storage and read-pipeline registers carry no reset; a reset
    // network on an array would defeat RAM inference, and the controller's
    // valid bits already mark their contents as dead after reset.
    always_ff @(posedge clk) begin
        if (we)  mem[wa] <= di;
        if (re)  ra_q    <= ra;
        if (ore) dout_q  <= mem[ra_q];
    end

    assign dout = dout_q;

    // Power-control bus has no behavioural effect in this model.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

endmodule

// File: rtl/sa_fifo_ctrl_128x6.sv
// ----------------------------------------------------------------------------
// sa_fifo_ctrl_128x6
// Valid/ready FIFO controller sequencing one sa_ram_rwsp_128x6 (128 x 6b).
// Ports:
//   clk, rstn       : clock, async active-low reset
//   bus (slave)     : push/pop handshake, rd_pd straight from RAM dout
//   pwrbus_ram_pd   : forwarded untouched to the RAM
//   fifo_count      : entries held (RAM slots + output register); present
//                     only when SA_FIFO_CTRL_COUNT_EN is defined
// Parameter AFULL_LVL (1..128): wr_afull when occupancy >= AFULL_LVL.
// ----------------------------------------------------------------------------
module sa_fifo_ctrl_128x6
    import sa_fifo_pkg::*;
#(
    parameter int AFULL_LVL = 120
)
(
    input  logic                    clk,
    input  logic                    rstn,
    sa_fifo_ctrl_128x6_if.slave     bus,
    input  logic [31:0]             pwrbus_ram_pd
`ifdef SA_FIFO_CTRL_COUNT_EN
    ,
    output sa_fifo_cnt_t            fifo_count
`endif
);

    sa_fifo_ptr_t wr_ptr_q,  wr_ptr_d;
    sa_fifo_ptr_t rd_ptr_q,  rd_ptr_d;
    sa_fifo_cnt_t ram_cnt_q, ram_cnt_d;  // slots not yet released by ore
    sa_fifo_cnt_t avail_q,   avail_d;    // written, not yet issued by re
    logic         s1_v_q,    s1_v_d;     // RAM address register live
    logic         s2_v_q,    s2_v_d;     // RAM output register live

    logic         push, pop, re, ore;
    sa_fifo_cnt_t occupancy;

    // wr_prdy looks only at registered state: no path from rd_prdy.
    assign bus.wr_prdy = (ram_cnt_q != sa_fifo_cnt_t'(SA_FIFO_DEPTH));
    assign bus.rd_pvld = s2_v_q;

    assign push = bus.wr_pvld & bus.wr_prdy;
    assign pop  = s2_v_q & bus.rd_prdy;
    // Advance S1 into S2 whenever S2 is free or being emptied this cycle.
    assign ore  = s1_v_q & (~s2_v_q | pop);
    // Issue a new address when S1 is free or moving on.
    assign re   = (avail_q != '0) & (~s1_v_q | ore);

    // Shared by wr_afull and the optional count output.
    assign occupancy    = ram_cnt_q + sa_fifo_cnt_t'(s2_v_q);
    assign bus.wr_afull = (occupancy >= sa_fifo_cnt_t'(AFULL_LVL));

`ifdef SA_FIFO_CTRL_COUNT_EN
    assign fifo_count = occupancy;
`endif

    // NOTE: every always_comb output gets its hold value first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        s1_v_d    = s1_v_q;
        s2_v_d    = s2_v_q;

        if (push) wr_ptr_d = wr_ptr_q + sa_fifo_ptr_t'(1);
        if (re)   rd_ptr_d = rd_ptr_q + sa_fifo_ptr_t'(1);

        // Push and ore together cancel, as do push and re.
        ram_cnt_d = ram_cnt_q + sa_fifo_cnt_t'(push) - sa_fifo_cnt_t'(ore);
        avail_d   = avail_q   + sa_fifo_cnt_t'(push) - sa_fifo_cnt_t'(re);

        if (re)       s1_v_d = 1'b1;
        else if (ore) s1_v_d = 1'b0;

        if (ore)      s2_v_d = 1'b1;
        else if (pop) s2_v_d = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            avail_q   <= '0;
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            avail_q   <= avail_d;
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
        end
    end

    sa_ram_rwsp_128x6 u_ram (
        .clk           (clk),
        .re            (re),
        .ore           (ore),
        .ra            (rd_ptr_q),
        .we            (push),
        .wa            (wr_ptr_q),
        .di            (bus.wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .dout          (bus.rd_pd)
    );

endmodule

// File: tb/tb_sa_fifo_ctrl_128x6.sv
// ----------------------------------------------------------------------------
// tb_sa_fifo_ctrl_128x6
// Self-checking bench. The reference keeps the accepted data in a queue
// (occupancy = queue size) plus a count of entries still waiting in RAM
// and flags for the two read stages; every cycle it predicts the handshake
// outputs and the head-of-queue data.
// ----------------------------------------------------------------------------
module tb_sa_fifo_ctrl_128x6;
    import sa_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pwrbus = 32'h0;

    always #5 clk = ~clk;

    sa_fifo_ctrl_128x6_if bus();

`ifdef SA_FIFO_CTRL_COUNT_EN
    sa_fifo_cnt_t fifo_count;
`endif

    sa_fifo_ctrl_128x6 #(.AFULL_LVL(120)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus),
        .pwrbus_ram_pd (pwrbus)
`ifdef SA_FIFO_CTRL_COUNT_EN
        ,
        .fifo_count    (fifo_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [5:0] q[$];      // accepted, not yet popped, in order
    int         n_wait;    // accepted, not yet sent into the read pipeline
    bit         in_s1;
    bit         in_s2;

    // Observations from the most recent cycle() call
    logic       seen_pvld, seen_prdy;
    logic [5:0] seen_pd;
    int         n_push_tot, n_pop_tot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        n_wait = 0;
        in_s1  = 1'b0;
        in_s2  = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance both.
    // Entered and left just after a falling edge.
    task automatic cycle(input bit pv, input logic [5:0] pd, input bit rr);
        bit m_prdy, push, pop, ore, re;
        bus.wr_pvld = pv;
        bus.wr_pd   = pd;
        bus.rd_prdy = rr;
        #1;
        m_prdy = (n_wait + int'(in_s1)) != SA_FIFO_DEPTH;
        check("wr_prdy",  bus.wr_prdy,  m_prdy);
        check("rd_pvld",  bus.rd_pvld,  in_s2);
        check("wr_afull", bus.wr_afull, q.size() >= 120);
`ifdef SA_FIFO_CTRL_COUNT_EN
        check("fifo_count", fifo_count, q.size());
`endif
        if (in_s2) check("rd_pd", bus.rd_pd, q[0]);
        seen_pvld = bus.rd_pvld;
        seen_prdy = bus.wr_prdy;
        seen_pd   = bus.rd_pd;

        push = pv && m_prdy;
        pop  = in_s2 && rr;
        ore  = in_s1 && (!in_s2 || pop);
        re   = (n_wait > 0) && (!in_s1 || ore);

        @(posedge clk);
        if (push) begin q.push_back(pd); n_push_tot++; end
        if (pop)  begin void'(q.pop_front()); n_pop_tot++; end
        n_wait = n_wait + int'(push) - int'(re);
        if (re)       in_s1 = 1'b1;
        else if (ore) in_s1 = 1'b0;
        if (ore)      in_s2 = 1'b1;
        else if (pop) in_s2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && q.size() != 0; i++) cycle(1'b0, 6'h0, 1'b1);
        check("drained", q.size(), 0);
    endtask

    // Push with rd_prdy low until the model reports no room; returns pushes accepted.
    task automatic fill(output int accepted);
        int start = n_push_tot;
        for (int i = 0; i < 200 && (n_wait + int'(in_s1)) != SA_FIFO_DEPTH; i++)
            cycle(1'b1, 6'(i & 6'h3F), 1'b0);
        accepted = n_push_tot - start;
    endtask

    initial begin
        int first_k, pv_count, acc;

        bus.wr_pvld = 1'b0;
        bus.wr_pd   = '0;
        bus.rd_prdy = 1'b0;
        n_push_tot  = 0;
        n_pop_tot   = 0;
        model_reset();

        // ---- reset values ----
        rstn = 1'b0;
        #2;
        check("rst_wr_prdy",  bus.wr_prdy,  1'b1);
        check("rst_rd_pvld",  bus.rd_pvld,  1'b0);
        check("rst_wr_afull", bus.wr_afull, 1'b0);
`ifdef SA_FIFO_CTRL_COUNT_EN
        check("rst_fifo_count", fifo_count, 0);
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // ---- single push latency: visible at cycle 3 ----
        cycle(1'b1, 6'h2A, 1'b1);
        first_k = -1;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 6'h0, 1'b1);
            if (seen_pvld === 1'b1 && first_k < 0) begin
                first_k = k;
                check("lat_data", seen_pd, 6'h2A);
            end
        end
        check("lat_cycles", first_k, 3);

        // ---- fill with rd_prdy low: 128 RAM slots + output register ----
        fill(acc);
        check("fill_accepted", acc, 129);
        check("full_wr_prdy", bus.wr_prdy, 1'b0);
        check("full_wr_afull", bus.wr_afull, 1'b1);
        drain(300);

        // ---- full, push attempt together with pop ----
        fill(acc);
        cycle(1'b1, 6'h11, 1'b1);
        check("full_push_refused", seen_prdy, 1'b0);
        cycle(1'b1, 6'h11, 1'b1);
        check("next_push_taken", seen_prdy, 1'b1);
        drain(300);

        // ---- continuous stream 300 cycles (pointers wrap twice) ----
        for (int i = 0; i < 300; i++) cycle(1'b1, 6'($urandom), 1'b1);
        drain(20);

        // ---- random valid / ready ----
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 1)));
        drain(300);
        check("push_pop_balance", n_pop_tot, n_push_tot);

        // ---- reset with entries held ----
        for (int i = 0; i < 10; i++) cycle(1'b1, 6'(i + 1), 1'b0);
        repeat (3) cycle(1'b0, 6'h0, 1'b0);
        check("pre_rst_pvld", bus.rd_pvld, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_pvld", bus.rd_pvld, 1'b0);
        check("mid_rst_prdy", bus.wr_prdy, 1'b1);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 6'h15, 1'b1);
        first_k  = -1;
        pv_count = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 6'h0, 1'b1);
            if (seen_pvld === 1'b1) begin
                pv_count++;
                if (first_k < 0) begin
                    first_k = k;
                    check("post_rst_data", seen_pd, 6'h15);
                end
            end
        end
        check("post_rst_lat", first_k, 3);
        check("post_rst_alone", pv_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
